// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Lock supervisor and reset sequencer for the system PLL.
//               Runs on the free-running reference clock. It pulses the PLL
//               reset and qualifies the PLL lock indication for stability.
//               It releases the design-wide reset only after lock has held
//               for a programmed interval. On lock loss the design reset is
//               re-asserted at once. The PLL is reset again if lock does not
//               return within the timeout.
//
// Parameters  : RST_CYCLES    - refclk cycles pll_rst is held per pulse (>=1)
//               STABLE_CYCLES - consecutive locked cycles before release (>=1)
//               LOCK_TIMEOUT  - cycles allowed in WAIT_LOCK/LOST (>=1)
//               CNT_W         - width of lock_loss_cnt
//
// Ports       : refclk        in   reference clock, free-running
//               rst_n         in   asynchronous active-low reset
//               locked        in   PLL lock, asynchronous to refclk
//               force_relock  in   single-cycle PLL restart request
//               pll_rst       out  active-high PLL reset (registered)
//               sys_rst_n     out  active-low design reset (registered)
//               state         out  FSM state encoding
//               lock_loss_cnt out  saturating count of RUN->LOST events
//
// Build macro : PLL_SUP_LOSS_CNT_EN - when defined, the lock-loss counter is
//               built. When undefined, lock_loss_cnt is tied to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    // ------------------------------------------------------------------------
    // State encodings (externally visible on the state port)
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_RESET_PLL = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_STABLE    = 3'd2;
    localparam logic [2:0] c_ST_RUN       = 3'd3;
    localparam logic [2:0] c_ST_LOST      = 3'd4;

    // ------------------------------------------------------------------------
    // Shared cycle counter sizing. It is wide enough for the largest interval.
    // The floor of 1 bit keeps the vector legal when every interval is 1.
    // ------------------------------------------------------------------------
    localparam int c_MAX_RS  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int c_MAX_CYC = (c_MAX_RS > LOCK_TIMEOUT) ? c_MAX_RS : LOCK_TIMEOUT;
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    // Terminal counts: each interval of N cycles ends when the counter reads N-1
    localparam logic [c_CNT_W-1:0] c_RST_LAST     = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic               r_sync_meta;     // first synchronizer stage
    logic               r_locked_s;      // synchronized lock, the FSM's only view
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_rst_done;
    logic               w_stable_done;
    logic               w_timeout;
    logic               r_pll_rst;
    logic               r_sys_rst_n;
    logic               w_pll_rst_nxt;
    logic               w_sys_rst_n_nxt;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous lock indication
    // ------------------------------------------------------------------------
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_locked_s  <= 1'b0;
        end else begin
            r_sync_meta <= locked;
            r_locked_s  <= r_sync_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Interval terminal-count decode
    // ------------------------------------------------------------------------
    assign w_rst_done    = (r_cnt == c_RST_LAST);
    assign w_stable_done = (r_cnt == c_STABLE_LAST);
    assign w_timeout     = (r_cnt == c_TIMEOUT_LAST);

    // ------------------------------------------------------------------------
    // FSM process 1: state register, shared counter and output flops.
    // The outputs load from the next-state decode so that they switch on the
    // same edge as the state. Each output comes straight from a flop, so no
    // decode glitch can reach the PLL or the design reset tree.
    // ------------------------------------------------------------------------
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_RESET_PLL;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pll_rst   <= w_pll_rst_nxt;
            r_sys_rst_n <= w_sys_rst_n_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state decode.
    // force_relock outranks every lock-driven transition. RESET_PLL does not
    // check it, so a request during the pulse neither restarts nor stretches
    // the pulse.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RESET_PLL: begin
                if (w_rst_done) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end
            end
            c_ST_WAIT_LOCK: begin
                if (force_relock) begin
                    w_state_nxt = c_ST_RESET_PLL;
                end else if (r_locked_s) begin
                    w_state_nxt = c_ST_STABLE;
                end else if (w_timeout) begin
                    w_state_nxt = c_ST_RESET_PLL;
                end
            end
            c_ST_STABLE: begin
                // A drop during qualification is not a loss event.
                // Qualification restarts from WAIT_LOCK.
                if (force_relock) begin
                    w_state_nxt = c_ST_RESET_PLL;
                end else if (!r_locked_s) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                end else if (w_stable_done) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (force_relock) begin
                    w_state_nxt = c_ST_RESET_PLL;
                end else if (!r_locked_s) begin
                    w_state_nxt = c_ST_LOST;
                end
            end
            c_ST_LOST: begin
                if (force_relock) begin
                    w_state_nxt = c_ST_RESET_PLL;
                end else if (r_locked_s) begin
                    w_state_nxt = c_ST_STABLE;
                end else if (w_timeout) begin
                    w_state_nxt = c_ST_RESET_PLL;
                end
            end
            default: begin
                // Encodings 5-7 can only come from an upset. Recover through
                // a full PLL reset.
                w_state_nxt = c_ST_RESET_PLL;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: output decode. It works on the next state, and the
    // decoded values feed the output flops.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pll_rst_nxt   = 1'b0;
        w_sys_rst_n_nxt = 1'b0;
        if (w_state_nxt == c_ST_RESET_PLL) begin
            w_pll_rst_nxt = 1'b1;
        end
        if (w_state_nxt == c_ST_RUN) begin
            w_sys_rst_n_nxt = 1'b1;
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst_n = r_sys_rst_n;
    assign state     = r_state;

    // ------------------------------------------------------------------------
    // Lock-loss counter. It counts only real RUN->LOST transitions, and a
    // force_relock in RUN is not a loss. Only rst_n clears it, so the count
    // survives relock requests.
    // ------------------------------------------------------------------------
`ifdef PLL_SUP_LOSS_CNT_EN
    logic             w_loss_event;
    logic [CNT_W-1:0] r_loss_cnt;

    assign w_loss_event = (r_state == c_ST_RUN) && (w_state_nxt == c_ST_LOST);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_event && (r_loss_cnt != {CNT_W{1'b1}})) begin
            r_loss_cnt <= r_loss_cnt + CNT_W'(1);
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Self-checking bench for pll_lock_supervisor. Directed
//               scenarios for power-up, unstable lock, loss with recovery,
//               timeouts, force_relock, async reset and counter saturation.
//               These are followed by a randomized phase. Every cycle is
//               compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int CNT_W         = 2;

`ifdef PLL_SUP_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    // Phase numbers taken from the documented state encodings
    localparam int P_RESET  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_LOST   = 4;

    logic             refclk = 1'b0;
    logic             rst_n = 1'b0;
    logic             locked = 1'b0;
    logic             force_relock = 1'b0;
    logic             pll_rst;
    logic             sys_rst_n;
    logic [2:0]       state;
    logic [CNT_W-1:0] lock_loss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .locked       (locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .state        (state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    // ------------------------------------------------------------------------
    // Reference model. The phase, the time spent in it, the loss count, and
    // the history of sampled lock values. The FSM sees the value that was
    // sampled two edges earlier.
    // ------------------------------------------------------------------------
    int m_phase;
    int m_age;
    int m_loss;
    bit q_lk[$];

    function automatic void model_reset();
        m_phase = P_RESET;
        m_age   = 0;
        m_loss  = 0;
        q_lk.delete();
        q_lk.push_back(1'b0);
        q_lk.push_back(1'b0);
    endfunction

    function automatic void model_edge(input bit lk, input bit fr);
        bit ls;
        int nxt;
        ls  = q_lk[0];
        nxt = m_phase;
        if (fr && m_phase != P_RESET) begin
            nxt = P_RESET;
        end else begin
            case (m_phase)
                P_RESET:  if (m_age + 1 >= RST_CYCLES) nxt = P_WAIT;
                P_WAIT:   if (ls) nxt = P_STABLE;
                          else if (m_age + 1 >= LOCK_TIMEOUT) nxt = P_RESET;
                P_STABLE: if (!ls) nxt = P_WAIT;
                          else if (m_age + 1 >= STABLE_CYCLES) nxt = P_RUN;
                P_RUN:    if (!ls) begin
                              nxt = P_LOST;
                              if (m_loss < (1 << CNT_W) - 1) m_loss = m_loss + 1;
                          end
                P_LOST:   if (ls) nxt = P_STABLE;
                          else if (m_age + 1 >= LOCK_TIMEOUT) nxt = P_RESET;
                default:  nxt = P_RESET;
            endcase
        end
        m_age   = (nxt == m_phase) ? m_age + 1 : 0;
        m_phase = nxt;
        void'(q_lk.pop_front());
        q_lk.push_back(lk);
    endfunction

    function automatic int exp_loss(input int v);
        return LOSS_EN ? v : 0;
    endfunction

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ph);
        check_eq({ph, ".state"},     32'(state),         32'(m_phase));
        check_eq({ph, ".pll_rst"},   32'(pll_rst),       32'(m_phase == P_RESET));
        check_eq({ph, ".sys_rst_n"}, 32'(sys_rst_n),     32'(m_phase == P_RUN));
        check_eq({ph, ".loss_cnt"},  32'(lock_loss_cnt), 32'(exp_loss(m_loss)));
    endtask

    // One rising edge. The model advances with the inputs present at the
    // edge, and the outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge refclk);
        if (rst_n) model_edge(locked, force_relock);
        #1;
        check_outputs("cyc");
    endtask

    task automatic run_to_run();
        int g;
        g = 0;
        while (state !== 3'd3 && g < 200) begin
            step();
            g++;
        end
        check_eq("reach_run", 32'(state), 32'(P_RUN));
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge refclk);
        #1;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int n;
        int g;
        model_reset();

        // Reset state
        rst_n = 1'b0;
        locked = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        check_outputs("reset");

        // Power-up: count the edges that occur while pll_rst is high
        rst_n = 1'b1;
        n = 0; g = 0;
        while (pll_rst === 1'b1 && g < 20) begin
            n++; g++;
            step();
        end
        check_eq("pwrup_pll_rst_edges", 32'(n), 32'(RST_CYCLES));
        check_eq("pwrup_wait_lock", 32'(state), 32'(P_WAIT));
        locked = 1'b1;
        repeat (3) step();                       // e0, e0+1, e0+2
        check_eq("pwrup_stable_at_e0p2", 32'(state), 32'(P_STABLE));
        repeat (STABLE_CYCLES - 1) step();
        check_eq("pwrup_held_in_reset", 32'(sys_rst_n), 32'd0);
        step();                                  // e0+2+STABLE_CYCLES
        check_eq("pwrup_release", 32'(sys_rst_n), 32'd1);

        // Lock loss with recovery
        locked = 1'b0;
        repeat (3) step();
        check_eq("loss_state_lost", 32'(state), 32'(P_LOST));
        check_eq("loss_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check_eq("loss_cnt_1", 32'(lock_loss_cnt), 32'(exp_loss(1)));
        locked = 1'b1;
        repeat (3) step();
        check_eq("recover_stable", 32'(state), 32'(P_STABLE));
        repeat (STABLE_CYCLES - 1) step();
        check_eq("recover_not_yet", 32'(state), 32'(P_STABLE));
        step();
        check_eq("recover_run", 32'(state), 32'(P_RUN));

        // Force relock in RUN. A second request during the pulse is ignored.
        force_relock = 1'b1;
        step();
        force_relock = 1'b0;
        check_eq("force_pll_rst", 32'(pll_rst), 32'd1);
        check_eq("force_sys_rst_n", 32'(sys_rst_n), 32'd0);
        n = 0; g = 0;
        while (pll_rst === 1'b1 && g < 20) begin
            force_relock = (n == 1);
            n++; g++;
            step();
            force_relock = 1'b0;
        end
        check_eq("force_pulse_len", 32'(n), 32'(RST_CYCLES));
        check_eq("force_wait_lock", 32'(state), 32'(P_WAIT));
        step();
        check_eq("force_to_stable", 32'(state), 32'(P_STABLE));

        // Unstable lock: a one-cycle drop after 5 qualified cycles
        repeat (5) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        repeat (2) step();
        check_eq("unstable_wait", 32'(state), 32'(P_WAIT));
        check_eq("unstable_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check_eq("unstable_no_loss", 32'(lock_loss_cnt), 32'(exp_loss(1)));
        step();
        check_eq("unstable_requal", 32'(state), 32'(P_STABLE));
        repeat (STABLE_CYCLES - 1) step();
        check_eq("unstable_full_qual", 32'(state), 32'(P_STABLE));
        step();
        check_eq("unstable_run", 32'(state), 32'(P_RUN));

        // force_relock on the edge where the FSM first acts on locked_s low
        locked = 1'b0;
        repeat (2) step();
        force_relock = 1'b1;
        step();
        force_relock = 1'b0;
        check_eq("force_vs_loss_state", 32'(state), 32'(P_RESET));
        check_eq("force_vs_loss_cnt", 32'(lock_loss_cnt), 32'(exp_loss(1)));

        // Lock loss with timeout, then a WAIT_LOCK timeout
        locked = 1'b1;
        run_to_run();
        locked = 1'b0;
        repeat (3) step();
        check_eq("to_lost", 32'(state), 32'(P_LOST));
        n = 0; g = 0;
        while (state === 3'd4 && g < 100) begin
            n++; g++;
            step();
        end
        check_eq("lost_timeout_len", 32'(n), 32'(LOCK_TIMEOUT));
        check_eq("lost_timeout_pll_rst", 32'(pll_rst), 32'd1);
        n = 0; g = 0;
        while (pll_rst === 1'b1 && g < 20) begin
            n++; g++;
            step();
        end
        check_eq("timeout_pulse_len", 32'(n), 32'(RST_CYCLES));
        n = 0; g = 0;
        while (state === 3'd1 && g < 100) begin
            n++; g++;
            step();
        end
        check_eq("wait_timeout_len", 32'(n), 32'(LOCK_TIMEOUT));
        check_eq("wait_timeout_reset", 32'(state), 32'(P_RESET));

        // rst_n asserted mid-RUN takes effect without a clock edge
        locked = 1'b1;
        run_to_run();
        #3;
        async_reset("midrun_rst");

        // Saturation: 5 loss events with CNT_W=2
        for (int i = 1; i <= 5; i++) begin
            locked = 1'b1;
            run_to_run();
            locked = 1'b0;
            repeat (3) step();
            check_eq($sformatf("sat_loss_%0d", i), 32'(lock_loss_cnt),
                     32'(exp_loss((i < 3) ? i : 3)));
        end
        locked = 1'b1;

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 23) == 0) locked = ~locked;
            force_relock = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 799) == 0) begin
                #2;
                async_reset("rnd_rst");
            end
            step();
        end
        force_relock = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: guarantees termination if the stimulus ever stalls
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
